// File: rtl/multi_port_fifo.sv
// multi_port_fifo: multi-lane push/pop FIFO with occupancy counter; define MULTI_PORT_FIFO_BYPASS_EN for empty-queue bypass
module multi_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PUSH_W     = 4,
  parameter int POP_W      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [$clog2(PUSH_W+1)-1:0]      push_num,
  input  logic [PUSH_W*DATA_WIDTH-1:0]     push_data,
  output logic                             push_stall,
  input  logic [$clog2(POP_W+1)-1:0]       pop_num,
  output logic [POP_W*DATA_WIDTH-1:0]      pop_data,
  output logic [$clog2(POP_W+1)-1:0]       pop_avail,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int PNW   = $clog2(PUSH_W+1);
  localparam int PPW   = $clog2(POP_W+1);
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]         free;
  logic [PNW-1:0]        acc_push, skip;
  logic [PPW-1:0]        eff_pop;
  logic                  byp;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // credit check, pop window and bypass selection, all from registered state
  always_comb begin
    free       = CW'(DEPTH) - count;
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    byp        = (count == '0) && !flush;
`else
    byp        = 1'b0;
`endif
    push_stall = CW'(push_num) > free;
    acc_push   = push_stall ? '0 : push_num;
    pop_avail  = byp ? (32'(acc_push) >= POP_W ? PPW'(POP_W) : PPW'(acc_push))
                     : (32'(count) >= POP_W ? PPW'(POP_W) : PPW'(count));
    eff_pop    = pop_num > pop_avail ? pop_avail : pop_num;
    skip       = byp ? PNW'(eff_pop) : '0;
  end
  for (genvar j = 0; j < POP_W; j++) begin : g_pop
    if (j < PUSH_W) begin : g_fwd
      assign pop_data[j*DATA_WIDTH +: DATA_WIDTH] = byp ? push_data[j*DATA_WIDTH +: DATA_WIDTH]
                                                        : ram[rd_ptr + PTR_W'(j)];
    end else begin : g_ram
      assign pop_data[j*DATA_WIDTH +: DATA_WIDTH] = ram[rd_ptr + PTR_W'(j)];
    end
  end
  // pointers and occupancy; flush beats push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(acc_push);
      rd_ptr <= rd_ptr + PTR_W'(eff_pop);
      count  <= count + CW'(acc_push) - CW'(eff_pop);
    end
  end
  // storage write; lanes consumed by bypass leave their slots unwritten but still advance wr_ptr
  always_ff @(posedge clk) begin
    if (rst && !flush)
      for (int i = 0; i < PUSH_W; i++)
        if (i < int'(acc_push) && i >= int'(skip))
          ram[wr_ptr + PTR_W'(i)] <= push_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_multi_port_fifo.sv
// tb_multi_port_fifo: table-driven vectors plus bypass and async-reset sequences
module tb_multi_port_fifo;
  logic        clk = 0;
  logic        rst = 0;
  logic        flush = 0;
  logic [2:0]  push_num = 0;
  logic [127:0] push_data = 0;
  logic        push_stall;
  logic [1:0]  pop_num = 0;
  logic [63:0] pop_data;
  logic [1:0]  pop_avail;
  logic [4:0]  count;
  logic        full, empty;
  int n_chk = 0;
  int n_err = 0;

  multi_port_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .push_num(push_num), .push_data(push_data),
    .push_stall(push_stall), .pop_num(pop_num), .pop_data(pop_data), .pop_avail(pop_avail),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fl; int pn; int base; int on; int stall; int avail; int p0; int p1; int cnt;
  } vec_t;
  vec_t tv[31];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit fl, input int pn, input int base, input int on);
    flush = fl;
    push_num = 3'(pn);
    pop_num = 2'(on);
    for (int i = 0; i < 4; i++) push_data[i*32 +: 32] = 32'(base + i);
  endtask

  task automatic check_state(input string tag, input int c);
    chk({tag, " count"}, int'(count), c);
    chk({tag, " full"}, int'(full), int'(c == 16));
    chk({tag, " empty"}, int'(empty), int'(c == 0));
  endtask

  initial begin
    tv[0]  = '{0, 4,   0, 0, 0, -1,   0,   0,  4};
    tv[1]  = '{0, 4,   4, 0, 0,  2,   0,   1,  8};
    tv[2]  = '{0, 4,   8, 0, 0,  2,   0,   1, 12};
    tv[3]  = '{0, 4,  12, 0, 0,  2,   0,   1, 16};
    tv[4]  = '{0, 1, 100, 0, 1,  2,   0,   1, 16};
    tv[5]  = '{0, 0,   0, 2, 0,  2,   0,   1, 14};
    tv[6]  = '{0, 4, 200, 0, 1,  2,   2,   3, 14};
    tv[7]  = '{0, 2,  20, 0, 0,  2,   2,   3, 16};
    tv[8]  = '{0, 0,   0, 2, 0,  2,   2,   3, 14};
    tv[9]  = '{0, 0,   0, 2, 0,  2,   4,   5, 12};
    tv[10] = '{0, 0,   0, 2, 0,  2,   6,   7, 10};
    tv[11] = '{0, 0,   0, 2, 0,  2,   8,   9,  8};
    tv[12] = '{0, 0,   0, 2, 0,  2,  10,  11,  6};
    tv[13] = '{0, 0,   0, 2, 0,  2,  12,  13,  4};
    tv[14] = '{0, 0,   0, 1, 0,  2,  14,  15,  3};
    tv[15] = '{0, 4,  30, 2, 0,  2,  15,  20,  5};
    tv[16] = '{0, 4,  40, 2, 0,  2,  21,  30,  7};
    tv[17] = '{0, 4,  50, 2, 0,  2,  31,  32,  9};
    tv[18] = '{1, 3,  60, 2, 0,  2,  33,  40,  0};
    tv[19] = '{0, 0,   0, 2, 0,  0,   0,   0,  0};
    tv[20] = '{0, 1,  70, 0, 0, -1,   0,   0,  1};
    tv[21] = '{0, 0,   0, 2, 0,  1,  70,   0,  0};
    tv[22] = '{0, 4,  80, 0, 0, -1,   0,   0,  4};
    tv[23] = '{0, 4,  90, 2, 0,  2,  80,  81,  6};
    tv[24] = '{0, 4, 100, 2, 0,  2,  82,  83,  8};
    tv[25] = '{0, 4, 110, 2, 0,  2,  90,  91, 10};
    tv[26] = '{0, 0,   0, 2, 0,  2,  92,  93,  8};
    tv[27] = '{0, 0,   0, 2, 0,  2, 100, 101,  6};
    tv[28] = '{0, 0,   0, 2, 0,  2, 102, 103,  4};
    tv[29] = '{0, 0,   0, 2, 0,  2, 110, 111,  2};
    tv[30] = '{0, 0,   0, 2, 0,  2, 112, 113,  0};

    #12;
    check_state("reset", 0);
    chk("reset pop_avail", int'(pop_avail), 0);
    chk("reset push_stall", int'(push_stall), 0);
    @(negedge clk);
    rst = 1;

    for (int k = 0; k < 31; k++) begin
      string tag;
      tag = $sformatf("v%0d", k);
      @(negedge clk);
      drive(tv[k].fl, tv[k].pn, tv[k].base, tv[k].on);
      #1;
      chk({tag, " push_stall"}, int'(push_stall), tv[k].stall);
      if (tv[k].avail >= 0) begin
        chk({tag, " pop_avail"}, int'(pop_avail), tv[k].avail);
        if (tv[k].avail > 0) chk({tag, " pop_data0"}, int'(pop_data[31:0]), tv[k].p0);
        if (tv[k].avail > 1) chk({tag, " pop_data1"}, int'(pop_data[63:32]), tv[k].p1);
      end
      @(posedge clk);
      #1;
      check_state(tag, tv[k].cnt);
    end

    // empty queue, push A,B,C with pop 2: forwarded only when bypass is built in
    @(negedge clk);
    drive(0, 3, 'hA0, 2);
    #1;
    chk("byp stall", int'(push_stall), 0);
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    chk("byp avail", int'(pop_avail), 2);
    chk("byp data0", int'(pop_data[31:0]), 'hA0);
    chk("byp data1", int'(pop_data[63:32]), 'hA1);
    @(posedge clk);
    #1;
    check_state("byp next", 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("byp next avail", int'(pop_avail), 1);
    chk("byp next data0", int'(pop_data[31:0]), 'hA2);
`else
    chk("nobyp avail", int'(pop_avail), 0);
    @(posedge clk);
    #1;
    check_state("nobyp next", 3);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("nobyp next avail", int'(pop_avail), 2);
    chk("nobyp next data0", int'(pop_data[31:0]), 'hA0);
    chk("nobyp next data1", int'(pop_data[63:32]), 'hA1);
`endif
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(posedge clk);
    #1;
    check_state("flush clear", 0);

    // asynchronous reset in the middle of a push
    @(negedge clk);
    drive(0, 4, 'h300, 0);
    @(posedge clk);
    #1;
    check_state("pre-reset", 4);
    @(negedge clk);
    drive(0, 4, 'h310, 0);
    #2;
    rst = 0;
    #1;
    check_state("async reset", 0);
    chk("async reset avail", int'(pop_avail), 0);
    @(posedge clk);
    #1;
    check_state("held reset", 0);
    @(negedge clk);
    rst = 1;
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_state("after reset", 0);
    chk("after reset avail", int'(pop_avail), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multi_port_fifo.md
Name: multi_port_fifo

Overview:
- Parametrised successor to the single-entry instruction/data queue.
- Accepts up to PUSH_W entries and releases up to POP_W entries per cycle, in strict FIFO order.
- Uses full DEPTH capacity (no reserved slot) via an explicit occupancy counter.
- Sits between fetch and decode as a superscalar instruction buffer; also reusable for any multi-lane decoupling queue.

Parameters:
- DATA_WIDTH, 32, bits per entry
- DEPTH, 16, entries; power of two, >= max(PUSH_W, POP_W)
- PUSH_W, 4, max entries written per cycle
- POP_W, 2, max entries read per cycle

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  synchronous clear of all contents and pointers
- push_num  in  $clog2(PUSH_W+1)  number of valid push lanes this cycle; lanes 0..push_num-1, lane 0 oldest
- push_data  in  PUSH_W*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- push_stall  out  1  push group rejected this cycle
- pop_num  in  $clog2(POP_W+1)  number of entries consumer takes this cycle
- pop_data  out  POP_W*DATA_WIDTH  lane 0 = oldest entry
- pop_avail  out  $clog2(POP_W+1)  number of valid pop lanes
- count  out  $clog2(DEPTH+1)  current occupancy (registered)
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage: DEPTH x DATA_WIDTH distributed RAM.
  - Storage is not reset.
  - Write pointer wr_ptr and read pointer rd_ptr are PTR_WIDTH = $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (rst = 0, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0. Resulting outputs:
  - empty = 1, full = 0, pop_avail = 0, push_stall = 0 when push_num = 0.
  - pop_data is undefined.
- free = DEPTH - count, computed from registered count only. Same-cycle pops do not create push credit.
- push_stall = (push_num > free). This is combinational.
  - On stall, the whole group is dropped: nothing is written and wr_ptr is unchanged.
  - Partial acceptance never occurs.
- Accepted push (push_num <= free, flush = 0):
  - ram[wr_ptr + i] <= lane i, for i < push_num.
  - wr_ptr += push_num.
- pop_avail = min(count, POP_W). This is combinational from registered state.
- pop_data lane j = ram[rd_ptr + j] for j < pop_avail.
  - Lanes >= pop_avail are don't-care.
- Pop latency is 0 cycles: data is visible in the same cycle it is counted.
- An entry written at edge N is poppable in cycle N+1.
- Pop: the effective number popped is eff_pop = min(pop_num, pop_avail). Over-request is clamped, not an error.
  - rd_ptr += eff_pop.
- count update: count_next = count + accepted_push_num - eff_pop, with accepted_push_num = 0 on stall. Push and pop in the same cycle are both honoured.
- flush = 1 (synchronous):
  - wr_ptr, rd_ptr and count go to 0 next cycle.
  - Any same-cycle push and pop are discarded.
  - Flush wins over every other event.
- Wrap-around: pointer additions are truncated to PTR_WIDTH; a multi-lane write or read may straddle index DEPTH-1 -> 0.
- Reset asserted mid-operation: state clears immediately and asynchronously; no partial write completes.
- Invariant: 0 <= count <= DEPTH at all times.

Optional Feature:
- Macro: MULTI_PORT_FIFO_BYPASS_EN.
- Defined, when count == 0 and flush = 0:
  - Accepted push lanes are forwarded combinationally to pop_data.
  - pop_avail = min(accepted push_num, POP_W).
  - Bypassed entries consumed this cycle (eff_pop of them) are not written to storage.
  - The remaining lanes are written starting at wr_ptr. rd_ptr and wr_ptr both advance consistently.
  - Result: 0-cycle fill latency when empty.
- Not defined:
  - No forwarding; an empty FIFO gives pop_avail = 0 regardless of push.
  - Minimum push-to-pop latency is 1 cycle.
- push_stall is unaffected by the macro.

Test Plan:
- Reset then fill: release rst, push_num = 4 for 4 cycles with data 0..15 (DEPTH = 16, POP_W = 2) -> count 4, 8, 12, 16; full = 1; push_stall = 0 on each push.
- Overflow reject: from count = 14, push_num = 4 -> push_stall = 1, count stays 14, storage unchanged; push_num = 2 next cycle -> accepted, count = 16.
- Order and wrap: pre-fill so rd_ptr = 15, then push 4 and pop 2 per cycle -> pop_data lanes are the exact sequence across index 15 -> 0; count changes +2 per cycle.
- Pop clamp: count = 1, pop_num = 2 -> pop_avail = 1, eff_pop = 1, next count = 0, empty = 1.
- Simultaneous flush: count = 9, flush = 1 with push_num = 3 and pop_num = 2 -> next cycle count = 0, empty = 1, pointers 0; the pushed data is never popped.
- Bypass (macro defined): empty FIFO, push_num = 3 data A, B, C, pop_num = 2 -> same cycle pop_data = A, B; next cycle count = 1, pop_data lane 0 = C. Without the macro: same stimulus gives pop_avail = 0, next count = 3.
